// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed N-digit 7-segment scan controller
//
// Walks one active-low anode per digit with dead time at the start of each slot.
// Drives the shared nibble and decimal point. The shown value is double-buffered
// so it only changes on frame boundaries.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          1 = scan running, 0 = display dark
//   load        1-cycle strobe, captures value into the shadow register
//   value       4*N_DIGITS nibbles; digit 0 is least significant
//   dp_mask     decimal point per digit, 1 = lit (sampled live)
//   lz_blank    1 = suppress leading zeros (sampled live)
//   nib         nibble to the segment decoder
//   dig_an      anode enables, active low, at most one low at a time
//   dp_n        decimal point, active low
//   frame_done  1-cycle pulse on the first cycle of each new frame
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic                    lz_blank,
  output logic [3:0]              nib,
  output logic [N_DIGITS-1:0]     dig_an,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SLOT_END  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0  = N_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*N_DIGITS-1:0]   shadow;
  logic [4*N_DIGITS-1:0]   disp;

  logic [N_DIGITS-1:0]     lz_mask;
  logic                    upper_zero;
  logic                    digit_lit;
  logic [N_DIGITS-1:0]     show_an;
  logic                    show_dp;
  logic [IDX_W-1:0]        next_idx;

  // Digit i (i>0) is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_blank & upper_zero;
    end
  end

  // Anode / decimal point for the current slot; a blanked digit stays fully dark.
  assign digit_lit = ~lz_mask[idx];
  assign show_an   = digit_lit ? ~(ONE_HOT0 << idx) : '1;
  assign show_dp   = ~(digit_lit & dp_mask[idx]);
  assign next_idx  = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      disp       <= '0;
      nib        <= 4'h0;
      dig_an     <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      frame_done <= 1'b0;

      if (!en) begin
        state  <= IDLE;
        idx    <= '0;
        cnt    <= '0;
        dig_an <= '1;
        dp_n   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // Frame boundary: disp takes the pre-load shadow, so a coincident
            // load is seen one frame later.
            state  <= BLANK;
            idx    <= '0;
            cnt    <= '0;
            disp   <= shadow;
            nib    <= shadow[3:0];
            dig_an <= '1;
            dp_n   <= 1'b1;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_END) begin
              state  <= SHOW;
              dig_an <= show_an;
              dp_n   <= show_dp;
            end
          end
          SHOW: begin
            if (cnt == SLOT_END) begin
              state  <= BLANK;
              cnt    <= '0;
              dig_an <= '1;
              dp_n   <= 1'b1;
              if (idx == LAST_IDX) begin
                idx        <= '0;
                disp       <= shadow;
                nib        <= shadow[3:0];
                frame_done <= 1'b1;
              end else begin
                idx <= next_idx;
                nib <= disp[4*next_idx +: 4];
              end
            end else begin
              // Re-evaluated every cycle so dp_mask / lz_blank act live.
              cnt    <= cnt + 1'b1;
              dig_an <= show_an;
              dp_n   <= show_dp;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard testbench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [3:0]  nib;
  logic [3:0]  dig_an;
  logic        dp_n;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       nv;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  seg7_scan_ctrl #(
    .N_DIGITS    (4),
    .SLOT_CYCLES (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .lz_blank  (lz_blank),
    .nib       (nib),
    .dig_an    (dig_an),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, check the one-anode rule and pop any pending expectation.
  always @(negedge clk) begin
    exp_t e;
    check("onehot_anode", 32'($countones(~dig_an) <= 1), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("dig_an#%0d", n_pop), {28'd0, dig_an}, {28'd0, e.an});
      check($sformatf("dp_n#%0d", n_pop), {31'd0, dp_n}, {31'd0, e.dp});
      check($sformatf("frame_done#%0d", n_pop), {31'd0, frame_done}, {31'd0, e.fd});
      if (e.nv) begin
        check($sformatf("nib#%0d", n_pop), {28'd0, nib}, {28'd0, e.nib});
      end
      n_pop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cyc(input logic [3:0] an, input logic [3:0] n, input logic nv,
                          input logic dp, input logic fd);
    exp_t e;
    e.an  = an;
    e.nib = n;
    e.nv  = nv;
    e.dp  = dp;
    e.fd  = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  // One 8-cycle slot: 2 dark cycles then 6 cycles with the digit's anode low.
  task automatic push_slot(input int d, input logic [3:0] n, input logic lit,
                           input logic dp_lit, input logic fd);
    logic [3:0] an;
    an = lit ? ~(4'b0001 << d) : 4'hF;
    push_cyc(4'hF, n, 1'b1, 1'b1, fd);
    push_cyc(4'hF, n, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push_cyc(an, n, 1'b1, ~(lit & dp_lit), 1'b0);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] lit,
                            input logic [3:0] dpm, input logic fd);
    for (int d = 0; d < 4; d++) push_slot(d, v[4*d +: 4], lit[d], dpm[d], fd && (d == 0));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_mask  = 4'h0;
    lz_blank = 1'b0;

    // Reset state, then hold dark while en=0
    tick();
    tick();
    check("rst_dig_an", {28'd0, dig_an}, 32'hF);
    check("rst_nib", {28'd0, nib}, 32'h0);
    check("rst_dp_n", {31'd0, dp_n}, 32'd1);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    tick();
    push_idle(4);
    wait_empty();

    // Basic scan of 1234, mid-frame load of ABCD, load coincident with the wrap
    value = 16'h1234;
    load  = 1'b1;
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0);
    push_frame(16'hABCD, 4'hF, 4'h0, 1'b1);
    push_frame(16'hABCD, 4'hF, 4'h0, 1'b1);
    push_frame(16'h5678, 4'hF, 4'h0, 1'b1);
    repeat (10) tick();
    value = 16'hABCD;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (52) tick();
    value = 16'h5678;
    load  = 1'b1;
    tick();
    load = 1'b0;
    wait_empty();

    // Leading-zero blanking and decimal point
    en       = 1'b0;
    value    = 16'h0050;
    load     = 1'b1;
    lz_blank = 1'b1;
    dp_mask  = 4'b0010;
    tick();
    load = 1'b0;
    push_idle(1);
    en = 1'b1;
    tick();
    push_frame(16'h0050, 4'b0011, 4'b0010, 1'b0);
    push_frame(16'h0000, 4'b0001, 4'b0010, 1'b1);
    repeat (9) tick();
    value = 16'h0000;
    load  = 1'b1;
    tick();
    load = 1'b0;
    wait_empty();

    // en drops during SHOW of digit 2, then re-enable restarts at digit 0
    en       = 1'b0;
    lz_blank = 1'b0;
    dp_mask  = 4'h0;
    value    = 16'h1234;
    load     = 1'b1;
    tick();
    load = 1'b0;
    push_idle(1);
    en = 1'b1;
    tick();
    push_slot(0, 4'h4, 1'b1, 1'b0, 1'b0);
    push_slot(1, 4'h3, 1'b1, 1'b0, 1'b0);
    push_cyc(4'hF, 4'h2, 1'b1, 1'b1, 1'b0);
    push_cyc(4'hF, 4'h2, 1'b1, 1'b1, 1'b0);
    push_cyc(4'b1011, 4'h2, 1'b1, 1'b1, 1'b0);
    push_cyc(4'b1011, 4'h2, 1'b1, 1'b1, 1'b0);
    push_idle(2);
    repeat (19) tick();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    push_slot(0, 4'h4, 1'b1, 1'b0, 1'b0);
    push_cyc(4'hF, 4'h3, 1'b1, 1'b1, 1'b0);
    push_cyc(4'hF, 4'h3, 1'b1, 1'b1, 1'b0);
    push_cyc(4'b1101, 4'h3, 1'b1, 1'b1, 1'b0);
    push_cyc(4'b1101, 4'h3, 1'b1, 1'b1, 1'b0);
    repeat (11) tick();

    // Asynchronous reset between edges while digit 1 is lit
    #5;
    check("drained_before_reset", exp_q.size(), 0);
    check("pre_reset_dig_an", {28'd0, dig_an}, 32'hD);
    rst_n = 1'b0;
    #1;
    check("async_rst_dig_an", {28'd0, dig_an}, 32'hF);
    check("async_rst_nib", {28'd0, nib}, 32'h0);
    check("async_rst_dp_n", {31'd0, dp_n}, 32'd1);
    check("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_dig_an", {28'd0, dig_an}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
